cordic_share_ctrl: RTL and testbench

//  Time-multiplexes one pipelined CORDIC rotator among NCH requesters.
//  - Round-robin grant of one request per cycle; channel tag carried in a delay line matched to the CORDIC latency.
//  - Results returned through a 2-entry output buffer with valid/ready.
//  - Back-pressure is applied by gating the CORDIC clock-enable, so no in-flight result is ever lost.
//  - Sits between DSP channel logic and the shared cordic instance in the parent.

---
 rtl/cordic_pkg.sv | 17 +
 rtl/cordic_rr_arbiter.sv | 33 +++
 rtl/cordic_share_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cordic_share_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the CORDIC sharing controller.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package cordic_pkg;

  // Pipeline depth of the shared rotator, aux-in to aux-out, in ce-cycles.
  localparam int unsigned CORDIC_LAT = 21;

  // Result buffer depth; ce drops when this many results are held.
  localparam int unsigned OBUF_DEPTH = 2;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Rotating-priority arbiter: first requester at or after ptr wins.
// Latency: combinational.
// Backpressure: none here; the caller qualifies the grant with its own enable.
module cordic_rr_arbiter #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = 2
) (
  input  logic [NCH-1:0] req_i,
  input  logic [CHW-1:0] ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [CHW-1:0] idx_o,
  output logic           vld_o
);

  // Scan NCH positions starting at ptr, wrapping once; first hit is granted.
  always_comb begin
    int c;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    c     = 0;
    for (int k = 0; k < int'(NCH); k++) begin
      c = int'(ptr_i) + k;
      if (c >= int'(NCH)) c = c - int'(NCH);
      if (!vld_o && req_i[c]) begin
        vld_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = CHW'(c);
      end
    end
  end

endmodule

// File: rtl/cordic_share_ctrl.sv
// Shares one pipelined CORDIC among NCH requesters; tags travel in a matched delay line.
// Latency: request accepted in cycle t -> result valid LAT+1 cycles later, plus one per stall cycle.
// Backpressure: CORDIC ce is dropped when the 2-entry result buffer is full, freezing everything in flight.
module cordic_share_ctrl
  import cordic_pkg::*;
#(
  parameter  int unsigned NCH = 4,
  parameter  int unsigned IW  = 12,
  parameter  int unsigned OW  = 12,
  parameter  int unsigned PW  = 19,
  parameter  int unsigned LAT = CORDIC_LAT,
  localparam int unsigned CHW = ch_width(NCH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NCH-1:0]    i_req_valid,
  output logic [NCH-1:0]    o_req_ready,
  input  logic [NCH*IW-1:0] i_req_x,
  input  logic [NCH*IW-1:0] i_req_y,
  input  logic [NCH*PW-1:0] i_req_phase,
  output logic              o_cd_ce,
  output logic              o_cd_aux,
  output logic [IW-1:0]     o_cd_x,
  output logic [IW-1:0]     o_cd_y,
  output logic [PW-1:0]     o_cd_phase,
  input  logic              i_cd_aux,
  input  logic [OW-1:0]     i_cd_x,
  input  logic [OW-1:0]     i_cd_y,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [CHW-1:0]    o_res_ch,
  output logic [OW-1:0]     o_res_x,
  output logic [OW-1:0]     o_res_y,
  output logic              o_busy
);

  localparam int unsigned IFW       = $clog2(LAT + 1);
  localparam logic [1:0]  OBUF_FULL = 2'(OBUF_DEPTH);

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [OW-1:0]  x;
    logic [OW-1:0]  y;
  } res_t;

  logic [CHW-1:0] ptr_q, ptr_d;
  logic [NCH-1:0] gnt;
  logic [CHW-1:0] gnt_idx;
  logic           gnt_vld;
  logic           issue;

  logic [CHW-1:0] tag_q [LAT];

  res_t           obuf_q [OBUF_DEPTH];
  logic           wr_ptr_q, rd_ptr_q;
  logic [1:0]     cnt_q, cnt_d;
  logic           push, pop;
  res_t           push_ent, head;

  logic [IFW-1:0] infl_q, infl_d;

  cordic_rr_arbiter #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .req_i (i_req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  // ce comes only from the registered buffer count, so ready never reaches ce combinationally.
  assign o_cd_ce     = (cnt_q < OBUF_FULL);
  assign issue       = gnt_vld & o_cd_ce & ~i_reset;
  assign o_req_ready = gnt & {NCH{issue}};
  assign o_cd_aux    = issue;

  // Steer the granted channel's operands to the rotator; zeros when idle.
  always_comb begin
    int unsigned sel;
    sel        = 32'(gnt_idx);
    o_cd_x     = '0;
    o_cd_y     = '0;
    o_cd_phase = '0;
    if (issue) begin
      o_cd_x     = i_req_x[sel*IW +: IW];
      o_cd_y     = i_req_y[sel*IW +: IW];
      o_cd_phase = i_req_phase[sel*PW +: PW];
    end
  end

  // After a grant the pointer moves just past the winner; otherwise it holds.
  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      if (gnt_idx == CHW'(NCH - 1)) ptr_d = '0;
      else                          ptr_d = gnt_idx + CHW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  // Channel tags advance in lockstep with the rotator so the tail lines up with i_cd_aux.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(LAT); i++) tag_q[i] <= '0;
    end else if (o_cd_ce) begin
      tag_q[0] <= gnt_idx;
      for (int i = 1; i < int'(LAT); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // A held rotator output under ce=0 is the same result, so only ce-qualified aux pushes.
  assign push     = i_cd_aux & o_cd_ce;
  assign pop      = o_res_valid & i_res_ready;
  assign push_ent = '{ch: tag_q[LAT-1], x: i_cd_x, y: i_cd_y};
  assign head     = obuf_q[rd_ptr_q];

  // Buffer occupancy; push and pop together leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Two-entry result buffer storage and pointers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(OBUF_DEPTH); i++) obuf_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        obuf_q[wr_ptr_q] <= push_ent;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  assign o_res_valid = (cnt_q != 2'd0);
  assign o_res_ch    = o_res_valid ? head.ch : '0;
  assign o_res_x     = o_res_valid ? head.x  : '0;
  assign o_res_y     = o_res_valid ? head.y  : '0;

  // Requests inside the rotator: up on issue, down on push.
  always_comb begin
    infl_d = infl_q;
    case ({issue, push})
      2'b10:   infl_d = infl_q + IFW'(1);
      2'b01:   infl_d = infl_q - IFW'(1);
      default: infl_d = infl_q;
    endcase
  end

  // In-flight counter register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) infl_q <= '0;
    else         infl_q <= infl_d;
  end

  assign o_busy = (infl_q != '0) | (cnt_q != 2'd0);

endmodule

// File: tb/tb_cordic_share_ctrl.sv
// Directed bench: a stand-in rotator (x+phase, y-phase, LAT ce-stages) plus an in-order scoreboard.
// Latency: checks request-to-result of LAT+1 cycles.
// Backpressure: exercises result ready low, ce stalls and mid-flight reset.
module tb_cordic_share_ctrl;

  localparam int NCH = 4;
  localparam int IW  = 12;
  localparam int OW  = 12;
  localparam int PW  = 19;
  localparam int LAT = 21;
  localparam int CHW = 2;

  logic              clk, rst;
  logic [NCH-1:0]    req_valid, req_ready;
  logic [NCH*IW-1:0] req_x, req_y;
  logic [NCH*PW-1:0] req_phase;
  logic              cd_ce, cd_aux_o, cd_aux_i;
  logic [IW-1:0]     cd_x_o, cd_y_o;
  logic [PW-1:0]     cd_phase;
  logic [OW-1:0]     cd_x_i, cd_y_i;
  logic              res_valid, res_ready;
  logic [CHW-1:0]    res_ch;
  logic [OW-1:0]     res_x, res_y;
  logic              busy;

  logic [IW-1:0] dx [NCH];
  logic [IW-1:0] dy [NCH];
  logic [PW-1:0] dp [NCH];

  int n_tests = 0;
  int n_fail  = 0;
  int n_issued = 0;
  int n_popped = 0;

  int            q_ch [$];
  logic [OW-1:0] q_x  [$];
  logic [OW-1:0] q_y  [$];

  logic [LAT-1:0] m_aux;
  logic [OW-1:0]  m_x [LAT];
  logic [OW-1:0]  m_y [LAT];

  cordic_share_ctrl #(
    .NCH(NCH), .IW(IW), .OW(OW), .PW(PW), .LAT(LAT)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_x     (req_x),
    .i_req_y     (req_y),
    .i_req_phase (req_phase),
    .o_cd_ce     (cd_ce),
    .o_cd_aux    (cd_aux_o),
    .o_cd_x      (cd_x_o),
    .o_cd_y      (cd_y_o),
    .o_cd_phase  (cd_phase),
    .i_cd_aux    (cd_aux_i),
    .i_cd_x      (cd_x_i),
    .i_cd_y      (cd_y_i),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_ch    (res_ch),
    .o_res_x     (res_x),
    .o_res_y     (res_y),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_x     = '0;
    req_y     = '0;
    req_phase = '0;
    for (int c = 0; c < NCH; c++) begin
      req_x[c*IW +: IW]     = dx[c];
      req_y[c*IW +: IW]     = dy[c];
      req_phase[c*PW +: PW] = dp[c];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Stand-in rotator: LAT ce-gated stages, reset with the controller; records expected results.
  assign cd_aux_i = m_aux[LAT-1];
  assign cd_x_i   = m_x[LAT-1];
  assign cd_y_i   = m_y[LAT-1];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_aux <= '0;
      for (int i = 0; i < LAT; i++) begin
        m_x[i] <= '0;
        m_y[i] <= '0;
      end
      q_ch.delete();
      q_x.delete();
      q_y.delete();
    end else if (cd_ce) begin
      m_aux  <= {m_aux[LAT-2:0], cd_aux_o};
      m_x[0] <= cd_x_o + cd_phase[OW-1:0];
      m_y[0] <= cd_y_o - cd_phase[OW-1:0];
      for (int i = 1; i < LAT; i++) begin
        m_x[i] <= m_x[i-1];
        m_y[i] <= m_y[i-1];
      end
      if (cd_aux_o) begin
        int fc;
        fc = 7;
        for (int c = NCH - 1; c >= 0; c--)
          if (cd_x_o == dx[c] && cd_y_o == dy[c] && cd_phase == dp[c]) fc = c;
        q_ch.push_back(fc);
        if (fc < NCH) begin
          q_x.push_back(dx[fc] + dp[fc][OW-1:0]);
          q_y.push_back(dy[fc] - dp[fc][OW-1:0]);
        end else begin
          q_x.push_back('0);
          q_y.push_back('0);
        end
        n_issued++;
      end
    end
  end

  // Result monitor: each accepted result must be the oldest outstanding one.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready) begin
        chk("res_expected", 32'(q_ch.size() != 0), 32'd1);
        if (q_ch.size() != 0) begin
          chk("res_ch", 32'(res_ch), 32'(q_ch.pop_front()));
          chk("res_x",  32'(res_x),  32'(q_x.pop_front()));
          chk("res_y",  32'(res_y),  32'(q_y.pop_front()));
        end
        n_popped++;
      end
      if (!cd_ce) chk("stall_only_when_full", 32'(res_valid), 32'd1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, run, stalls, i0, p0;
    int exp2 [8];
    int exp4 [8];
    int exp5 [3];
    exp2 = '{3, 0, 1, 2, 3, 0, 1, 2};
    exp4 = '{3, 0, 3, 0, 3, 0, 3, 0};
    exp5 = '{1, 2, 0};

    rst       = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      dx[c] = IW'(100 * (c + 1));
      dy[c] = IW'(10 * (c + 1));
      dp[c] = PW'(50 * c);
    end

    // Reset state
    repeat (3) @(posedge clk);
    smp();
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_cd_aux",    32'(cd_aux_o), 0);
    chk("rst_res_x",     32'(res_x), 0);
    chk("rst_res_ch",    32'(res_ch), 0);
    tick(); rst = 1'b0;

    // 1: single ch2 request, x=1000 y=0 phase=0
    dx[2] = 12'd1000; dy[2] = 12'd0; dp[2] = '0;
    tick(); req_valid = 4'b0100;
    smp();
    chk("t1_ready", 32'(req_ready), 32'b0100);
    chk("t1_cd_aux", 32'(cd_aux_o), 1);
    chk("t1_cd_x", 32'(cd_x_o), 1000);
    lat = 0;
    do begin
      tick(); req_valid = '0;
      smp(); lat++;
    end while (!res_valid && lat < 60);
    chk("t1_latency", 32'(lat), 32'(LAT + 1));
    chk("t1_ch", 32'(res_ch), 2);
    chk("t1_x", 32'(res_x), 1000);
    chk("t1_y", 32'(res_y), 0);
    tick(); smp();
    chk("t1_single_result", 32'(res_valid), 0);

    // 2: all channels valid; pointer sits at 3 after the ch2 grant
    for (int i = 0; i < 8; i++) begin
      tick(); req_valid = 4'hF;
      smp();
      chk("t2_grant", 32'(req_ready), 32'(1 << exp2[i]));
    end
    tick(); req_valid = '0;
    lat = 0;
    while (!res_valid && lat < 60) begin tick(); smp(); lat++; end
    chk("t2_timeout", 32'(lat < 60), 1);
    run = 0;
    while (res_valid && run < 20) begin run++; tick(); smp(); end
    chk("t2_back_to_back", 32'(run), 8);
    chk("t2_sb_empty", 32'(q_ch.size()), 0);

    // 3: continuous stream, result ready low for 10 cycles
    i0 = n_issued; p0 = n_popped;
    for (int i = 0; i < 30; i++) begin tick(); req_valid = 4'hF; smp(); end
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); res_ready = 1'b0;
      smp();
      if (!cd_ce) stalls++;
    end
    chk("t3_ready_gated", 32'(req_ready), 0);
    chk("t3_buf_valid", 32'(res_valid), 1);
    chk("t3_stall_cycles", 32'(stalls), 9);
    for (int i = 0; i < 5; i++) begin tick(); res_ready = 1'b1; smp(); end
    tick(); req_valid = '0;
    lat = 0;
    while (busy && lat < 100) begin tick(); smp(); lat++; end
    chk("t3_drain_timeout", 32'(lat < 100), 1);
    chk("t3_issued", 32'(n_issued - i0), 35);
    chk("t3_returned", 32'(n_popped - p0), 35);
    chk("t3_sb_empty", 32'(q_ch.size()), 0);

    // 4: park pointer at 2 with a ch1 request, then ch0+ch3 alternate
    tick(); req_valid = 4'b0010;
    smp();
    chk("t4_park", 32'(req_ready), 32'b0010);
    for (int i = 0; i < 8; i++) begin
      tick(); req_valid = 4'b1001;
      smp();
      chk("t4_grant", 32'(req_ready), 32'(1 << exp4[i]));
    end
    tick(); req_valid = '0;
    lat = 0;
    while (busy && lat < 100) begin tick(); smp(); lat++; end
    chk("t4_drain_timeout", 32'(lat < 100), 1);

    // 5: three results with ready low; third sits at the rotator output under ce=0
    p0 = n_popped;
    for (int i = 0; i < 3; i++) begin
      tick(); req_valid = 4'b0111; res_ready = 1'b0;
      smp();
      chk("t5_grant", 32'(req_ready), 32'(1 << exp5[i]));
    end
    tick(); req_valid = '0;
    lat = 0;
    while (cd_ce && lat < 60) begin tick(); smp(); lat++; end
    chk("t5_full_timeout", 32'(lat < 60), 1);
    stalls = 0;
    for (int i = 0; i < 8; i++) begin tick(); smp(); if (!cd_ce && cd_aux_i) stalls++; end
    chk("t5_held_stall", 32'(stalls), 8);
    tick(); res_ready = 1'b1;
    lat = 0;
    while (busy && lat < 60) begin tick(); smp(); lat++; end
    chk("t5_drain_timeout", 32'(lat < 60), 1);
    chk("t5_result_count", 32'(n_popped - p0), 3);
    chk("t5_sb_empty", 32'(q_ch.size()), 0);

    // 6: reset with 5 requests in flight
    for (int i = 0; i < 5; i++) begin tick(); req_valid = 4'hF; smp(); end
    tick(); req_valid = '0;
    repeat (3) begin tick(); smp(); end
    chk("t6_busy_before", 32'(busy), 1);
    tick(); rst = 1'b1; req_valid = 4'hF;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_ready", 32'(req_ready), 0);
    chk("t6_rst_aux", 32'(cd_aux_o), 0);
    chk("t6_rst_valid", 32'(res_valid), 0);
    smp();
    chk("t6_rst_ready_held", 32'(req_ready), 0);
    tick(); smp();
    tick(); req_valid = '0; rst = 1'b0;
    run = 0;
    for (int i = 0; i < LAT + 5; i++) begin tick(); smp(); if (res_valid) run++; end
    chk("t6_no_stale", 32'(run), 0);
    chk("t6_idle", 32'(busy), 0);
    tick(); req_valid = 4'b0010;
    smp();
    chk("t6_new_grant", 32'(req_ready), 32'b0010);
    lat = 0;
    do begin
      tick(); req_valid = '0;
      smp(); lat++;
    end while (!res_valid && lat < 60);
    chk("t6_latency", 32'(lat), 32'(LAT + 1));
    chk("t6_ch", 32'(res_ch), 1);
    chk("t6_x", 32'(res_x), 250);
    chk("t6_y", 32'(res_y), 32'h0FE2);
    repeat (3) begin tick(); smp(); end
    chk("end_sb_empty", 32'(q_ch.size()), 0);
    chk("end_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
